// File: rtl/smag_mult_pkg.sv
// Shared types and constants for the sequential sign-magnitude multiplier.
package smag_mult_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned NumLegalSteps = 3;
  localparam int unsigned LegalSteps [NumLegalSteps] = '{1, 2, 4};

  function automatic bit is_legal_step(input int unsigned step);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < int'(NumLegalSteps); i++) begin
      if (LegalSteps[i] == step) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/smag_mult_step.sv
// One partial-product step: acc + (a * bits) << shift, all at 2*WIDTH bits.
module smag_mult_step
  import smag_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input  logic [2*WIDTH-1:0]         acc_i,
  input  logic [WIDTH-1:0]           a_i,
  input  logic [STEP-1:0]            bits_i,
  input  logic [$clog2(2*WIDTH)-1:0] shift_i,
  output logic [2*WIDTH-1:0]         sum_o
);

  logic [2*WIDTH-1:0] prod;

  assign prod  = {{WIDTH{1'b0}}, a_i} * {{(2*WIDTH-STEP){1'b0}}, bits_i};
  assign sum_o = acc_i + (prod << shift_i);

endmodule

// File: rtl/smag_mult_seq.sv
// Sequential sign-magnitude multiplier retiring STEP multiplier bits per cycle.
// Optional feature: define SMAG_MULT_ZERO_SKIP_EN to bypass RUN for zero operands.
module smag_mult_seq
  import smag_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               a_sign,
  input  logic               b_sign,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               negative,
  output logic               busy
);

  localparam int unsigned NumSteps = WIDTH / STEP;
  localparam int unsigned CntW     = $clog2(NumSteps) + 1;
  localparam int unsigned ShiftW   = $clog2(2 * WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sign_q, sign_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               neg_q, neg_d;

  logic               accept;
  logic               zero_op;
  logic               last_step;
  logic [ShiftW-1:0]  shift;
  logic [2*WIDTH-1:0] sum;

`ifdef SMAG_MULT_ZERO_SKIP_EN
  assign zero_op = (a == '0) || (b == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign accept    = in_valid && (state_q == StIdle);
  assign last_step = (cnt_q == CntW'(NumSteps - 1));
  assign shift     = ShiftW'(cnt_q) * ShiftW'(STEP);

  // b_q is shifted right each RUN cycle, so its low STEP bits are always the next slice.
  smag_mult_step #(
    .WIDTH(WIDTH),
    .STEP (STEP)
  ) u_step (
    .acc_i  (acc_q),
    .a_i    (a_q),
    .bits_i (b_q[STEP-1:0]),
    .shift_i(shift),
    .sum_o  (sum)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = zero_op ? StDone : StRun;
      StRun:   if (last_step) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
  end

  // Datapath next-state
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    sign_d = sign_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    p_d    = p_q;
    neg_d  = neg_q;
    if (accept) begin
      a_d    = a;
      b_d    = b;
      sign_d = a_sign ^ b_sign;
      acc_d  = '0;
      cnt_d  = '0;
      if (zero_op) begin
        p_d   = '0;
        neg_d = 1'b0;
      end
    end else if (state_q == StRun) begin
      acc_d = sum;
      b_d   = b_q >> STEP;
      cnt_d = cnt_q + CntW'(1);
      if (last_step) begin
        p_d   = sum;
        neg_d = sign_q && (sum != '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      sign_q <= 1'b0;
      acc_q  <= '0;
      cnt_q  <= '0;
      p_q    <= '0;
      neg_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      sign_q <= sign_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      p_q    <= p_d;
      neg_q  <= neg_d;
    end
  end

  assign p        = p_q;
  assign negative = neg_q;

endmodule

// File: tb/tb_smag_mult_seq.sv
// Directed bench for smag_mult_seq at (8,1), (8,2) and (16,4), plus a (16,4) reference-model run.
module tb_smag_mult_seq;

`ifdef SMAG_MULT_ZERO_SKIP_EN
  localparam int ZeroLat81 = 1;
  localparam int ZeroLat82 = 1;
`else
  localparam int ZeroLat81 = 9;
  localparam int ZeroLat82 = 5;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance 1: WIDTH=8, STEP=1
  logic        iv1 = 0, or1 = 0, as1 = 0, bs1 = 0;
  logic [7:0]  a1 = 0, b1 = 0;
  logic        ir1, ov1, n1, busy1;
  logic [15:0] p1;
  // Instance 2: WIDTH=8, STEP=2
  logic        iv2 = 0, or2 = 0, as2 = 0, bs2 = 0;
  logic [7:0]  a2 = 0, b2 = 0;
  logic        ir2, ov2, n2, busy2;
  logic [15:0] p2;
  // Instance 3: WIDTH=16, STEP=4
  logic        iv3 = 0, or3 = 0, as3 = 0, bs3 = 0;
  logic [15:0] a3 = 0, b3 = 0;
  logic        ir3, ov3, n3, busy3;
  logic [31:0] p3;

  smag_mult_seq #(.WIDTH(8), .STEP(1)) u_dut81 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .a_sign(as1),
    .b_sign(bs1), .out_valid(ov1), .out_ready(or1), .p(p1), .negative(n1), .busy(busy1)
  );
  smag_mult_seq #(.WIDTH(8), .STEP(2)) u_dut82 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .a_sign(as2),
    .b_sign(bs2), .out_valid(ov2), .out_ready(or2), .p(p2), .negative(n2), .busy(busy2)
  );
  smag_mult_seq #(.WIDTH(16), .STEP(4)) u_dut164 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .a(a3), .b(b3), .a_sign(as3),
    .b_sign(bs3), .out_valid(ov3), .out_ready(or3), .p(p3), .negative(n3), .busy(busy3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic run1(input logic [7:0] a, input logic as, input logic [7:0] b, input logic bs,
                      input bit scramble, output int lat);
    int t = 0;
    while (!ir1 && t < 40) begin @(negedge clk); t++; end
    if (!ir1) check("run1_ready_timeout", ir1, 1);
    iv1 = 1; a1 = a; b1 = b; as1 = as; bs1 = bs;
    @(negedge clk);
    iv1 = 0;
    lat = 1;
    while (!ov1 && lat < 40) begin
      if (scramble) begin
        a1 = 8'($urandom); b1 = 8'($urandom); as1 = 1'($urandom); bs1 = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    if (!ov1) check("run1_valid_timeout", ov1, 1);
  endtask

  task automatic run2(input logic [7:0] a, input logic as, input logic [7:0] b, input logic bs,
                      output int lat);
    iv2 = 1; a2 = a; b2 = b; as2 = as; bs2 = bs;
    @(negedge clk);
    iv2 = 0;
    lat = 1;
    while (!ov2 && lat < 40) begin @(negedge clk); lat++; end
    if (!ov2) check("run2_valid_timeout", ov2, 1);
    or2 = 1;
    @(negedge clk);
    or2 = 0;
  endtask

  task automatic handoff1();
    or1 = 1;
    @(negedge clk);
    or1 = 0;
  endtask

  initial begin
    int lat;
    int t;
    int nacc;
    int idx [3];
    logic [31:0] ep;
    logic en;

    repeat (2) @(negedge clk);
    rst = 0;
    check("rst_in_ready", ir1, 1);
    check("rst_out_valid", ov1, 0);
    check("rst_busy", busy1, 0);
    check("rst_p", p1, 0);
    check("rst_neg", n1, 0);
    check("rst_busy2", busy2, 0);
    check("rst_busy3", busy3, 0);
    check("rst_in_ready3", ir3, 1);

    // 255 * -255, then backpressure for 10 cycles with inputs wiggling
    run1(8'd255, 1'b0, 8'd255, 1'b1, 1'b0, lat);
    check("max_latency", lat, 9);
    check("max_p", p1, 65025);
    check("max_neg", n1, 1);
    for (int i = 0; i < 10; i++) begin
      iv1 = 1; a1 = 8'($urandom); b1 = 8'($urandom);
      @(negedge clk);
      check("bp_valid", ov1, 1);
      check("bp_in_ready", ir1, 0);
      check("bp_p", p1, 65025);
      check("bp_neg", n1, 1);
    end
    iv1 = 0;
    handoff1();
    check("handoff_valid", ov1, 0);
    check("handoff_in_ready", ir1, 1);
    check("handoff_busy", busy1, 0);
    check("hold_p", p1, 65025);
    check("hold_neg", n1, 1);

    // Operands changed mid-RUN are ignored
    run1(8'd12, 1'b1, 8'd10, 1'b1, 1'b1, lat);
    check("scramble_p", p1, 120);
    check("scramble_neg", n1, 0);
    handoff1();

    run1(8'd1, 1'b1, 8'd255, 1'b0, 1'b0, lat);
    check("one_p", p1, 255);
    check("one_neg", n1, 1);
    handoff1();
    run1(8'd128, 1'b0, 8'd2, 1'b0, 1'b0, lat);
    check("pow2_p", p1, 256);
    check("pow2_neg", n1, 0);
    handoff1();

    // Negative zero suppression
    run1(8'd0, 1'b1, 8'd5, 1'b0, 1'b0, lat);
    check("zero81_latency", lat, ZeroLat81);
    check("zero81_p", p1, 0);
    check("zero81_neg", n1, 0);
    handoff1();

    // Reset in the third RUN cycle aborts the operation
    iv1 = 1; a1 = 8'd200; b1 = 8'd100; as1 = 0; bs1 = 0;
    @(negedge clk);
    iv1 = 0;
    @(negedge clk);
    @(negedge clk);
    check("run_busy", busy1, 1);
    check("run_in_ready", ir1, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("abort_in_ready", ir1, 1);
    check("abort_valid", ov1, 0);
    check("abort_p", p1, 0);
    check("abort_busy", busy1, 0);
    en = 0;
    repeat (12) begin @(negedge clk); en = en | ov1; end
    check("abort_no_valid", en, 0);
    run1(8'd3, 1'b0, 8'd5, 1'b0, 1'b0, lat);
    check("post_abort_latency", lat, 9);
    check("post_abort_p", p1, 15);
    handoff1();

    // STEP=2 instance
    run2(8'd0, 1'b1, 8'd77, 1'b0, lat);
    check("zero82_latency", lat, ZeroLat82);
    check("zero82_p", p2, 0);
    check("zero82_neg", n2, 0);
    run2(8'd13, 1'b1, 8'd11, 1'b0, lat);
    check("s2_latency", lat, 5);
    check("s2_p", p2, 143);
    check("s2_neg", n2, 1);
    run2(8'd255, 1'b1, 8'd255, 1'b1, lat);
    check("s2_max_p", p2, 65025);
    check("s2_max_neg", n2, 0);

    // WIDTH=16, STEP=4: issue interval with out_ready held high
    or3 = 1; iv3 = 1; a3 = 16'd1234; b3 = 16'd567; as3 = 1; bs3 = 0;
    nacc = 0;
    for (int c = 0; c < 40; c++) begin
      if (ir3 && nacc < 3) begin idx[nacc] = c; nacc++; end
      @(negedge clk);
    end
    iv3 = 0;
    repeat (10) @(negedge clk);
    or3 = 0;
    check("interval_count", nacc, 3);
    check("interval_1", idx[1] - idx[0], 6);
    check("interval_2", idx[2] - idx[1], 6);
    check("burst_p", p3, 699678);
    check("burst_neg", n3, 1);

    // WIDTH=16, STEP=4: random operands against a reference product
    for (int i = 0; i < 2000; i++) begin
      a3 = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom);
      b3 = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom);
      as3 = 1'($urandom); bs3 = 1'($urandom);
      ep = 32'(a3) * 32'(b3);
      t = 0;
      while (!ir3 && t < 40) begin @(negedge clk); t++; end
      if (!ir3) check("rnd_ready_timeout", ir3, 1);
      iv3 = 1;
      @(negedge clk);
      iv3 = 0;
      a3 = 16'($urandom); b3 = 16'($urandom);
      t = 0;
      while (!ov3 && t < 40) begin @(negedge clk); t++; end
      if (!ov3) check("rnd_valid_timeout", ov3, 1);
      check("rnd_p", p3, ep);
      check("rnd_neg", n3, (as3 ^ bs3) && (ep != 0) ? 1 : 0);
      do begin
        or3 = 1'($urandom_range(0, 1));
        @(negedge clk);
      end while (!or3);
      or3 = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
